// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: shared widths for the memory scheduler
package mem_sched_pkg;
  localparam int MS_DWIDTH = 32;
  localparam int MS_AWIDTH_MEM = 32;
  localparam int MS_MASK_W = 4;
endpackage

// File: rtl/mem_sched_hold.sv
// mem_sched_hold: load-enabled register of a deferred lane-2 op with sync clear
module mem_sched_hold
  import mem_sched_pkg::*;
#(
  parameter int DWIDTH = MS_DWIDTH,
  parameter int AWIDTH_MEM = MS_AWIDTH_MEM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld,
  input  logic                  d_we,
  input  logic [MS_MASK_W-1:0]  d_mask,
  input  logic [AWIDTH_MEM-1:0] d_addr,
  input  logic [DWIDTH-1:0]     d_wdata,
  output logic                  q_we,
  output logic [MS_MASK_W-1:0]  q_mask,
  output logic [AWIDTH_MEM-1:0] q_addr,
  output logic [DWIDTH-1:0]     q_wdata
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q_we <= 1'b0;
      q_mask <= '0;
      q_addr <= '0;
      q_wdata <= '0;
    end else if (ld) begin
      q_we <= d_we;
      q_mask <= d_mask;
      q_addr <= d_addr;
      q_wdata <= d_wdata;
    end
  end
endmodule

// File: rtl/mem_sched.sv
// mem_sched: dual-lane scheduler onto a dual-port memory, serializing same-address hazards
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int DWIDTH = MS_DWIDTH,
  parameter int AWIDTH_MEM = MS_AWIDTH_MEM,
  parameter int CNT_W = 16
) (
  input  logic                  ms_clk,
  input  logic                  ms_rst,
  input  logic                  ms_i_req_1,
  input  logic                  ms_i_we_1,
  input  logic [MS_MASK_W-1:0]  ms_i_mask_1,
  input  logic [AWIDTH_MEM-1:0] ms_i_addr_1,
  input  logic [DWIDTH-1:0]     ms_i_wdata_1,
  input  logic                  ms_i_req_2,
  input  logic                  ms_i_we_2,
  input  logic [MS_MASK_W-1:0]  ms_i_mask_2,
  input  logic [AWIDTH_MEM-1:0] ms_i_addr_2,
  input  logic [DWIDTH-1:0]     ms_i_wdata_2,
  output logic                  ms_o_ack_1,
  output logic                  ms_o_ack_2,
  output logic                  ms_o_busy,
  output logic                  ms_o_rvalid_1,
  output logic [DWIDTH-1:0]     ms_o_rdata_1,
  output logic                  ms_o_rvalid_2,
  output logic [DWIDTH-1:0]     ms_o_rdata_2,
  output logic                  ms_o_ce,
  output logic                  ms_o_wr_en_1,
  output logic [MS_MASK_W-1:0]  ms_o_mask_1,
  output logic [AWIDTH_MEM-1:0] ms_o_addr_1,
  output logic [DWIDTH-1:0]     ms_o_wdata_1,
  output logic                  ms_o_wr_en_2,
  output logic [MS_MASK_W-1:0]  ms_o_mask_2,
  output logic [AWIDTH_MEM-1:0] ms_o_addr_2,
  output logic [DWIDTH-1:0]     ms_o_wdata_2,
  input  logic [DWIDTH-1:0]     ms_i_load_data_1,
  input  logic [DWIDTH-1:0]     ms_i_load_data_2,
  output logic [CNT_W-1:0]      ms_o_conflict_cnt
);
  typedef enum logic {RUN, REPLAY} state_t;
  state_t state, state_nxt;
  logic conflict, run, rep, act_1, act_2, hold_ld;
  logic h_we, p2_we;
  logic [MS_MASK_W-1:0] h_mask, p2_mask;
  logic [AWIDTH_MEM-1:0] h_addr, p2_addr;
  logic [DWIDTH-1:0] h_wdata, p2_wdata, rd_q_1, rd_q_2;
  assign conflict = ms_i_req_1 & ms_i_req_2 & (ms_i_addr_1 == ms_i_addr_2) & (ms_i_we_1 | ms_i_we_2);
  assign hold_ld = run & conflict;
  mem_sched_hold #(.DWIDTH(DWIDTH), .AWIDTH_MEM(AWIDTH_MEM)) u_hold (
    .clk(ms_clk),
    .rst(ms_rst),
    .ld(hold_ld),
    .d_we(ms_i_we_2),
    .d_mask(ms_i_mask_2),
    .d_addr(ms_i_addr_2),
    .d_wdata(ms_i_wdata_2),
    .q_we(h_we),
    .q_mask(h_mask),
    .q_addr(h_addr),
    .q_wdata(h_wdata)
  );
  always_ff @(posedge ms_clk) begin
    if (ms_rst) state <= RUN;
    else state <= state_nxt;
  end
  always_comb begin
    run = (state == RUN) & ~ms_rst;
    rep = (state == REPLAY) & ~ms_rst;
    state_nxt = hold_ld ? REPLAY : RUN;
    ms_o_busy = rep;
    ms_o_ack_1 = run & ms_i_req_1;
    ms_o_ack_2 = run & ms_i_req_2;
    act_1 = run & ms_i_req_1;
    act_2 = rep | (run & ms_i_req_2 & ~conflict);
    p2_we = rep ? h_we : ms_i_we_2;
    p2_mask = rep ? h_mask : ms_i_mask_2;
    p2_addr = rep ? h_addr : ms_i_addr_2;
    p2_wdata = rep ? h_wdata : ms_i_wdata_2;
    ms_o_ce = act_1 | act_2;
    ms_o_wr_en_1 = act_1 & ms_i_we_1;
    ms_o_mask_1 = act_1 ? ms_i_mask_1 : '0;
    ms_o_addr_1 = act_1 ? ms_i_addr_1 : '0;
    ms_o_wdata_1 = act_1 ? ms_i_wdata_1 : '0;
    ms_o_wr_en_2 = act_2 & p2_we;
    ms_o_mask_2 = act_2 ? p2_mask : '0;
    ms_o_addr_2 = act_2 ? p2_addr : '0;
    ms_o_wdata_2 = act_2 ? p2_wdata : '0;
  end
  // Read data is live on the memory bus in the return cycle and held afterwards
  assign ms_o_rdata_1 = ms_o_rvalid_1 ? ms_i_load_data_1 : rd_q_1;
  assign ms_o_rdata_2 = ms_o_rvalid_2 ? ms_i_load_data_2 : rd_q_2;
  always_ff @(posedge ms_clk) begin
    if (ms_rst) begin
      ms_o_rvalid_1 <= 1'b0;
      ms_o_rvalid_2 <= 1'b0;
      rd_q_1 <= '0;
      rd_q_2 <= '0;
      ms_o_conflict_cnt <= '0;
    end else begin
      ms_o_rvalid_1 <= act_1 & ~ms_o_wr_en_1;
      ms_o_rvalid_2 <= act_2 & ~ms_o_wr_en_2;
      rd_q_1 <= ms_o_rdata_1;
      rd_q_2 <= ms_o_rdata_2;
      if (hold_ld && !(&ms_o_conflict_cnt)) ms_o_conflict_cnt <= ms_o_conflict_cnt + 1'b1;
    end
  end
endmodule

// File: doc/mem_sched.md
MEM_SCHED -- requirements
Module: mem_sched

Interface
REQ-001 Parameter DWIDTH, default 32, data word width; taken from the shared definitions.
REQ-002 Parameter AWIDTH_MEM, default 32, word-index address width; taken from the shared definitions.
REQ-003 Parameter CNT_W, default 16, width of the conflict counter.
REQ-004 ms_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 ms_rst  in  1  synchronous, active-high reset.
REQ-006 ms_i_req_k (k=1,2)  in  1  lane k memory request valid; lane 1 is older in program order.
REQ-007 ms_i_we_k  in  1  lane k request is a store (1) or a load (0).
REQ-008 ms_i_mask_k  in  4  lane k byte-enable mask.
REQ-009 ms_i_addr_k  in  AWIDTH_MEM  lane k word address.
REQ-010 ms_i_wdata_k  in  DWIDTH  lane k store data.
REQ-011 ms_o_ack_k  out  1  lane k request accepted this cycle.
REQ-012 ms_o_busy  out  1  replay in progress; no new requests accepted this cycle.
REQ-013 ms_o_rvalid_k / ms_o_rdata_k  out  1 / DWIDTH  lane k load data return.
REQ-014 ms_o_ce, ms_o_wr_en_k, ms_o_mask_k, ms_o_addr_k, ms_o_wdata_k  out  1/1/4/AWIDTH_MEM/DWIDTH  drive the dual-port data memory.
REQ-015 ms_i_load_data_k  in  DWIDTH  memory port k read data, valid one cycle after the address is presented.
REQ-016 ms_o_conflict_cnt  out  CNT_W  count of serialized conflicts.

Function
REQ-017 The state machine SHALL have two states, RUN and REPLAY; ms_o_busy SHALL be 1 exactly when the state is REPLAY (Moore output).
REQ-018 Conflict: both ms_i_req_k are 1, ms_i_addr_1 == ms_i_addr_2, and ms_i_we_1 | ms_i_we_2 is 1; two loads to the same address are not a conflict.
REQ-019 RUN, no conflict: each requesting lane SHALL be driven combinationally onto its own memory port in the same cycle, ms_o_ack_k = ms_i_req_k, and the state SHALL remain RUN.
REQ-020 RUN, conflict: only lane 1 is issued, on port 1. Both acks SHALL be 1. Lane 2's op, mask, address and data SHALL be captured in the hold register. The next state SHALL be REPLAY. The counter SHALL increment.
REQ-021 REPLAY: the held op SHALL be issued on port 2 and port 1 SHALL be idle. All inputs SHALL be ignored, with ms_o_ack_k = 0. The next state SHALL be RUN unconditionally.
REQ-022 ms_o_ce = OR of the port activity; ms_o_wr_en_k = 1 only for an issued store; outputs of idle ports SHALL be 0.
REQ-023 A load issued on port k in cycle N SHALL produce ms_o_rvalid_k = 1 in cycle N+1, with ms_o_rdata_k = ms_i_load_data_k; otherwise rvalid SHALL be 0 and rdata SHALL hold its last value.
REQ-024 A replayed lane-2 load SHALL therefore return in cycle N+2 relative to the conflict cycle N.
REQ-025 The mask SHALL be passed unmodified; a store with mask 4'b0000 SHALL still be issued (memory no-op) and SHALL count as a store for conflict detection.
REQ-026 ms_o_conflict_cnt SHALL saturate at all-ones and never wrap.

Reset
REQ-027 While ms_rst = 1 at a clock edge: state SHALL go to RUN, the hold register SHALL be cleared, ms_o_rvalid_k SHALL be 0, ms_o_rdata_k SHALL be 0, and the counter SHALL be 0.
REQ-028 During the reset cycle, ms_o_ce, ms_o_wr_en_k, ms_o_ack_k and ms_o_busy SHALL be forced to 0.
REQ-029 Reset asserted during REPLAY SHALL discard the held op; it is never issued.

Structure
REQ-030 DWIDTH and AWIDTH_MEM SHALL come from the shared definitions package; the state encoding SHALL be a local constant.
REQ-031 The hold register SHALL be one sub-module, mem_sched_hold: a load-enabled register of {we, mask, addr, wdata} with synchronous clear.

Verification
REQ-032 Store lane1 {mask 1111, addr 3, data AABBCCDD} with load lane2 addr 7, same cycle -> both issued the same cycle; busy stays 0; rvalid_2 = 1 next cycle.
REQ-033 Store lane1 {mask 1111, addr 4, data 11223344} with load lane2 addr 4 -> cycle N: port 1 store only, acks 1/1, busy 0. N+1: busy 1, port 2 load addr 4. N+2: rvalid_2 = 1, rdata_2 = 11223344.
REQ-034 Two loads to addr 5, same cycle -> both issued, no busy, counter unchanged, both rvalid next cycle.
REQ-035 Two stores to addr 6 (lane1 data 0000EEFF mask 0011, lane2 data 00000099 mask 0001) -> lane1 issued in N, lane2 issued in N+1; counter = 1; a later load of addr 6 returns 0000EE99.
REQ-036 Conflict then ms_rst asserted in the REPLAY cycle -> no port-2 write occurs; state is RUN; counter = 0; all outputs 0.
REQ-037 Preload counter to FFFE via 3 consecutive conflicts with CNT_W = 16 -> counter reads FFFF and holds.
